// File: rtl/pkt_gen_pkg.sv
// pkt_gen_pkg: shared types, constants and helpers for the packet generator
package pkt_gen_pkg;
  localparam int META_PORT_W = 2;
  localparam int META_LEN_W = 6;
  localparam int META_TAG_W = 22;
  localparam int HDR_WORDS = 6;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
  localparam logic [47:0] DEF_MAC_BASE = 48'h02_00_00_00_00_00;
  typedef struct packed {
    logic [META_PORT_W-1:0] src;
    logic [META_PORT_W-1:0] dst;
    logic [META_LEN_W-1:0] len;
    logic [META_TAG_W-1:0] tag;
  } meta_t;
  typedef enum logic [1:0] {PAY_ONES, PAY_INC, PAY_LFSR, PAY_TAG} pay_mode_e;
  function automatic logic [47:0] port_to_mac(input logic [47:0] base, input logic [META_PORT_W-1:0] port);
    return base | 48'(port);
  endfunction
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/pkt_gen_stream_if.sv
// pkt_gen_stream_if: framed 32-bit valid/ready stream with sop/eop markers
interface pkt_gen_stream_if;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_data;
  logic out_sop;
  logic out_eop;
  modport master(output out_valid, out_data, out_sop, out_eop, input out_ready);
  modport slave(input out_valid, out_data, out_sop, out_eop, output out_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and full/empty flags
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd = rd_en && !empty;
  assign wr = wr_en && (!full || rd);
  // storage array; contents are don't-care until written
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_data;
  // pointers, occupancy and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      rd_data <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) begin
        rp <= rp + AW'(1);
        rd_data <= mem[rp];
      end
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/pkt_gen_stream.sv
// pkt_gen_stream: expands queued metadata descriptors into framed header+payload word streams
module pkt_gen_stream
  import pkt_gen_pkg::*;
#(
  parameter int META_DEPTH = 1024,
  parameter int BLOCK_BYTES = 32,
  parameter int LEN_W = 6,
  parameter int PORT_W = 2,
  parameter logic [47:0] MAC_BASE = DEF_MAC_BASE
) (
  input  logic clk,
  input  logic reset,
  input  logic meta_en,
  input  logic [31:0] meta_in,
  output logic meta_full,
  output logic meta_empty,
  input  logic [1:0] mode,
  input  logic gen_en,
  pkt_gen_stream_if.master st,
  output logic [31:0] pkt_sent,
  output logic [15:0] meta_drop
);
  localparam int WPB = BLOCK_BYTES / 4;
  localparam int TW_MAX = (2 ** LEN_W) * WPB;
  localparam int CW = $clog2(TW_MAX + 1);
  if (WPB < 7 || BLOCK_BYTES % 4 != 0 || (2 ** LEN_W) * BLOCK_BYTES > 65535 || META_DEPTH < 2 ||
      (META_DEPTH & (META_DEPTH - 1)) != 0 || LEN_W != META_LEN_W || PORT_W != META_PORT_W) begin : g_param_err
    $error("pkt_gen_stream: unsupported parameter combination");
  end
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_e;
  state_e state;
  meta_t desc;
  pay_mode_e mode_q;
  logic [31:0] rd_data, lfsr, word;
  logic [63:0] ts, ts_lat;
  logic [CW-1:0] cnt, tw, pidx;
  logic [15:0] len_bytes;
  logic [47:0] dmac, smac;
  logic pop, load, done;
  sync_fifo #(.WIDTH($bits(meta_t)), .DEPTH(META_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(meta_en),
    .wr_data(meta_in),
    .rd_en(pop),
    .rd_data(rd_data),
    .full(meta_full),
    .empty(meta_empty)
  );
  assign desc = meta_t'(rd_data);
  assign tw = CW'((int'(desc.len) + 1) * WPB);
  assign len_bytes = 16'((int'(desc.len) + 1) * BLOCK_BYTES);
  assign dmac = port_to_mac(MAC_BASE, desc.dst);
  assign smac = port_to_mac(MAC_BASE, desc.src);
  assign pidx = cnt - CW'(HDR_WORDS);
  assign load = state != IDLE && (!st.out_valid || st.out_ready);
  assign done = load && cnt == tw;
  assign pop = gen_en && !meta_empty && (state == IDLE || done);
  // next word to present, selected by its index within the packet
  always_comb
    word = cnt == 0 ? {len_bytes, dmac[47:32]} :
           cnt == 1 ? dmac[31:0] :
           cnt == 2 ? ts_lat[63:32] :
           cnt == 3 ? ts_lat[31:0] :
           cnt == 4 ? {16'h0, smac[47:32]} :
           cnt == 5 ? smac[31:0] :
           mode_q == PAY_ONES ? 32'hFFFF_FFFF :
           mode_q == PAY_INC ? 32'(pidx) :
           mode_q == PAY_LFSR ? lfsr : {10'h0, desc.tag};
  // packet FSM with registered stream outputs, timestamp, LFSR and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mode_q <= PAY_ONES;
      ts <= '0;
      ts_lat <= '0;
      lfsr <= LFSR_SEED;
      st.out_valid <= 1'b0;
      st.out_data <= '0;
      st.out_sop <= 1'b0;
      st.out_eop <= 1'b0;
      pkt_sent <= '0;
      meta_drop <= '0;
    end else begin
      ts <= ts + 64'd1;
      if (meta_en && meta_full && !pop && meta_drop != 16'hFFFF) meta_drop <= meta_drop + 16'd1;
      if (pop) begin
        state <= HDR;
        cnt <= '0;
        mode_q <= pay_mode_e'(mode);
        ts_lat <= ts;
      end
      if (done) begin
        st.out_valid <= 1'b0;
        st.out_sop <= 1'b0;
        st.out_eop <= 1'b0;
        pkt_sent <= pkt_sent + 32'd1;
        if (!pop) state <= IDLE;
      end else if (load) begin
        st.out_valid <= 1'b1;
        st.out_data <= word;
        st.out_sop <= cnt == 0;
        st.out_eop <= cnt == tw - CW'(1);
        cnt <= cnt + CW'(1);
        if (cnt == CW'(HDR_WORDS)) state <= PAY;
        if (cnt >= CW'(HDR_WORDS) && mode_q == PAY_LFSR) lfsr <= lfsr_next(lfsr);
      end
    end
  end
endmodule

// File: tb/tb_pkt_gen_stream.sv
// tb_pkt_gen_stream: directed and randomized checks of pkt_gen_stream against a queue-based model
module tb_pkt_gen_stream;
  localparam int DEPTH = 4;
  logic clk = 1'b0, reset = 1'b1, meta_en = 1'b0, gen_en = 1'b0;
  logic [31:0] meta_in = '0;
  logic [1:0] mode = '0;
  logic meta_full, meta_empty;
  logic [31:0] pkt_sent;
  logic [15:0] meta_drop;
  pkt_gen_stream_if st();
  pkt_gen_stream #(.META_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .meta_en(meta_en), .meta_in(meta_in),
    .meta_full(meta_full), .meta_empty(meta_empty), .mode(mode), .gen_en(gen_en),
    .st(st), .pkt_sent(pkt_sent), .meta_drop(meta_drop)
  );
  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  logic [31:0] mq[$];
  logic [33:0] exp_q[$];
  bit m_valid, m_pend, m_busy, armed, m_acc, m_eop, m_start;
  logic [31:0] m_sent, m_lfsr;
  logic [15:0] m_drop;
  logic [63:0] m_ts;
  logic [31:0] cap_d[$];
  bit cap_sop[$], cap_eop[$];
  int cap_cyc[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] mkd(input int src, input int dst, input int len, input int tag);
    return {2'(src), 2'(dst), 6'(len), 22'(tag)};
  endfunction

  function automatic void build(input logic [31:0] d, input logic [1:0] md, input logic [63:0] t);
    int len, tw;
    logic [15:0] lb;
    logic [47:0] dm, sm;
    logic [31:0] w;
    len = int'(d[27:22]);
    tw = (len + 1) * 8;
    lb = 16'((len + 1) * 32);
    dm = 48'h02_00_00_00_00_00 | 48'(d[29:28]);
    sm = 48'h02_00_00_00_00_00 | 48'(d[31:30]);
    for (int i = 0; i < tw; i++) begin
      if (i == 0) w = {lb, dm[47:32]};
      else if (i == 1) w = dm[31:0];
      else if (i == 2) w = t[63:32];
      else if (i == 3) w = t[31:0];
      else if (i == 4) w = {16'h0, sm[47:32]};
      else if (i == 5) w = sm[31:0];
      else if (md == 0) w = 32'hFFFF_FFFF;
      else if (md == 1) w = 32'(i - 6);
      else if (md == 2) begin
        w = m_lfsr;
        m_lfsr = lfsr_step(m_lfsr);
      end else w = {10'h0, d[21:0]};
      exp_q.push_back({i == 0, i == tw - 1, w});
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset && st.out_valid === 1'b1 && st.out_ready === 1'b1) begin
      cap_d.push_back(st.out_data);
      cap_sop.push_back(st.out_sop);
      cap_eop.push_back(st.out_eop);
      cap_cyc.push_back(cyc);
    end
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_valid = 0;
      m_pend = 0;
      m_busy = 0;
      m_sent = 0;
      m_drop = 0;
      m_ts = 0;
      m_lfsr = 32'hACE1_2468;
      armed = 1;
    end else begin
      m_acc = m_valid && st.out_ready;
      m_eop = m_acc && exp_q[0][32];
      m_start = (!m_busy || m_eop) && gen_en && mq.size() > 0;
      if (m_pend) begin
        m_valid = 1;
        m_pend = 0;
      end else if (m_acc) begin
        void'(exp_q.pop_front());
        if (m_eop) begin
          m_valid = 0;
          m_busy = 0;
          m_sent++;
        end
      end
      if (m_start) begin
        build(mq.pop_front(), mode, m_ts);
        m_pend = 1;
        m_busy = 1;
      end
      if (meta_en) begin
        if (mq.size() < DEPTH) mq.push_back(meta_in);
        else if (m_drop != 16'hFFFF) m_drop++;
      end
      m_ts++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("out_valid", st.out_valid, m_valid);
      if (m_valid) begin
        check("out_data", st.out_data, exp_q[0][31:0]);
        check("out_sop", st.out_sop, exp_q[0][33]);
        check("out_eop", st.out_eop, exp_q[0][32]);
      end
      check("meta_full", meta_full, mq.size() == DEPTH);
      check("meta_empty", meta_empty, mq.size() == 0);
      check("pkt_sent", pkt_sent, m_sent);
      check("meta_drop", meta_drop, m_drop);
    end
  end

  task automatic push(input logic [31:0] d);
    @(negedge clk);
    meta_en = 1;
    meta_in = d;
    @(negedge clk);
    meta_en = 0;
  endtask

  task automatic clear_caps();
    cap_d.delete();
    cap_sop.delete();
    cap_eop.delete();
    cap_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    meta_en = 0;
    @(negedge clk);
    reset = 0;
    clear_caps();
  endtask

  task automatic wait_caps(input int n, input int budget);
    int k = 0;
    while (cap_d.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_words", cap_d.size() >= n, 1);
  endtask

  initial begin
    logic [31:0] tmp;
    st.out_ready = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    check("lfsr_model", lfsr_step(32'h159C_248D), 32'h8AEE_1245);

    do_reset();
    check("rst_empty", meta_empty, 1);
    check("rst_valid", st.out_valid, 0);
    check("rst_sent", pkt_sent, 0);
    check("rst_drop", meta_drop, 0);
    mode = 0;
    gen_en = 1;
    push(mkd(1, 2, 0, 5));
    wait_caps(8, 50);
    check("a_w0", cap_d[0], 32'h0020_0200);
    check("a_w1", cap_d[1], 32'h0000_0002);
    check("a_w4", cap_d[4], 32'h0000_0200);
    check("a_w5", cap_d[5], 32'h0000_0001);
    check("a_w6", cap_d[6], 32'hFFFF_FFFF);
    check("a_w7", cap_d[7], 32'hFFFF_FFFF);
    check("a_sop0", cap_sop[0], 1);
    check("a_eop6", cap_eop[6], 0);
    check("a_eop7", cap_eop[7], 1);
    @(negedge clk);
    check("a_sent", pkt_sent, 1);

    do_reset();
    gen_en = 0;
    mode = 2;
    push(mkd(0, 1, 0, 1));
    push(mkd(2, 3, 0, 2));
    gen_en = 1;
    wait_caps(16, 100);
    check("b_p0", cap_d[6], 32'hACE1_2468);
    check("b_p1", cap_d[7], 32'h5670_9234);
    check("b_p2", cap_d[14], 32'h2B38_491A);
    check("b_p3", cap_d[15], 32'h159C_248D);
    check("b_sop8", cap_sop[8], 1);
    check("b_gap", cap_cyc[8] - cap_cyc[7], 2);

    do_reset();
    mode = 1;
    push(mkd(0, 3, 63, 7));
    wait_caps(512, 700);
    tmp = cap_d[0];
    check("c_lenb", tmp[31:16], 16'h0800);
    check("c_pay0", cap_d[6], 0);
    check("c_pay_last", cap_d[511], 505);
    check("c_eop", cap_eop[511], 1);
    check("c_eop510", cap_eop[510], 0);

    do_reset();
    mode = 0;
    push(mkd(3, 0, 0, 9));
    wait_caps(3, 50);
    st.out_ready = 0;
    repeat (5) @(negedge clk);
    st.out_ready = 1;
    wait_caps(8, 50);
    repeat (4) @(negedge clk);
    check("d_count", cap_d.size(), 8);

    do_reset();
    gen_en = 0;
    mode = 3;
    for (int i = 0; i < 6; i++) push(mkd(i % 4, (i + 1) % 4, 0, 'h10 + i));
    check("e_full", meta_full, 1);
    check("e_drop", meta_drop, 2);
    gen_en = 1;
    wait_caps(32, 200);
    repeat (20) @(negedge clk);
    check("e_count", cap_d.size(), 32);
    for (int p = 0; p < 4; p++) check("e_tag", cap_d[8 * p + 6], 'h10 + p);
    check("e_sent", pkt_sent, 4);

    clear_caps();
    mode = 0;
    push(mkd(1, 1, 1, 3));
    push(mkd(2, 2, 0, 4));
    wait_caps(3, 50);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("f_valid", st.out_valid, 0);
    check("f_empty", meta_empty, 1);
    check("f_sent", pkt_sent, 0);
    check("f_drop", meta_drop, 0);

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      tmp = $urandom;
      if ($urandom_range(0, 7) != 0) tmp[27:22] = 6'($urandom_range(0, 2));
      meta_en = $urandom_range(0, 3) == 0;
      meta_in = tmp;
      mode = 2'($urandom);
      gen_en = $urandom_range(0, 3) != 0;
      st.out_ready = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 499) == 0;
    end
    @(negedge clk);
    reset = 0;
    meta_en = 0;
    st.out_ready = 1;
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
